// File: rtl/audio_in_pkg.sv
// Shared state encoding and default constants for the audio level detector.
package audio_in_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        MAG    = 2'd1,
        UPDATE = 2'd2
    } state_e;

    localparam int SAMPLE_W  = 32;
    localparam int THRESHOLD = 5000000;

endpackage

// File: rtl/audio_sample_magnitude.sv
// Saturating absolute value of both stereo channels, reduced to the larger one.
module audio_sample_magnitude
    import audio_in_pkg::*;
#(
    parameter int SAMPLE_W = audio_in_pkg::SAMPLE_W
) (
    input  logic [SAMPLE_W-1:0] left_i,
    input  logic [SAMPLE_W-1:0] right_i,
    output logic [SAMPLE_W-2:0] mag_o
);

    logic [SAMPLE_W-1:0] neg_l;
    logic [SAMPLE_W-1:0] neg_r;
    logic [SAMPLE_W-2:0] abs_l;
    logic [SAMPLE_W-2:0] abs_r;

    // Negating the most-negative code leaves the sign bit set; that case saturates.
    always_comb begin
        neg_l = -left_i;
        neg_r = -right_i;
        abs_l = left_i[SAMPLE_W-2:0];
        abs_r = right_i[SAMPLE_W-2:0];
        if (left_i[SAMPLE_W-1]) begin
            abs_l = neg_l[SAMPLE_W-1] ? '1 : neg_l[SAMPLE_W-2:0];
        end
        if (right_i[SAMPLE_W-1]) begin
            abs_r = neg_r[SAMPLE_W-1] ? '1 : neg_r[SAMPLE_W-2:0];
        end
        mag_o = (abs_l > abs_r) ? abs_l : abs_r;
    end

endmodule

// File: rtl/audio_level_detector.sv
// Drains codec ADC samples, tracks per-window peak magnitude and pulses sound_detected
// after HOLD_WINDOWS consecutive loud windows. Optional macro: LOCKOUT_EN.
//   state  | meaning
//   WAIT   | idle until a sample is available, pop and capture it
//   MAG    | register max(|L|,|R|) of the captured sample
//   UPDATE | fold magnitude into window peak, close window on last sample
module audio_level_detector
    import audio_in_pkg::*;
#(
    parameter int SAMPLE_W       = audio_in_pkg::SAMPLE_W,
    parameter int WINDOW_LOG2    = 10,
    parameter int THRESHOLD      = audio_in_pkg::THRESHOLD,
    parameter int HOLD_WINDOWS   = 2,
    parameter int LOCKOUT_CYCLES = 50000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                enable,
    input  logic                audio_in_available,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic [SAMPLE_W-2:0] peak_level,
    output logic                level_valid,
    output logic                loud,
    output logic                sound_detected
);

    localparam logic [SAMPLE_W-2:0] THRESH_V = (SAMPLE_W-1)'(THRESHOLD);
    localparam logic [3:0]          HOLD_V   = 4'(HOLD_WINDOWS);

    state_e                 state_q;
    logic [SAMPLE_W-1:0]    left_q;
    logic [SAMPLE_W-1:0]    right_q;
    logic [SAMPLE_W-2:0]    mag_d;
    logic [SAMPLE_W-2:0]    mag_q;
    logic [SAMPLE_W-2:0]    win_peak_q;
    logic [SAMPLE_W-2:0]    peak_d;
    logic [SAMPLE_W-2:0]    peak_level_q;
    logic [WINDOW_LOG2-1:0] count_q;
    logic [3:0]             loud_cnt_q;
    logic                   level_valid_q;
    logic                   loud_q;
    logic                   sound_q;
    logic                   read_d;
    logic                   window_end;
    logic                   window_loud;
    logic                   fire;
    logic                   lockout_busy;

    if (HOLD_WINDOWS < 1 || HOLD_WINDOWS > 15 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("audio_level_detector: HOLD_WINDOWS must be 1..15 and LOCKOUT_CYCLES >= 1");
    end

    assign read_d      = !reset && enable && audio_in_available && (state_q == WAIT);
    assign peak_d      = (mag_q > win_peak_q) ? mag_q : win_peak_q;
    assign window_end  = enable && (state_q == UPDATE) && (count_q == '1);
    assign window_loud = (peak_d > THRESH_V);
    // Fires only on the step into HOLD_WINDOWS; a saturated count cannot re-trigger.
    assign fire        = window_end && window_loud && !lockout_busy
                         && (loud_cnt_q == HOLD_V - 4'd1);

    audio_sample_magnitude #(
        .SAMPLE_W(SAMPLE_W)
    ) u_mag (
        .left_i (left_q),
        .right_i(right_q),
        .mag_o  (mag_d)
    );

`ifdef LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    logic [LOCK_W-1:0] lockout_q;

    assign lockout_busy = (lockout_q != '0);

    always_ff @(posedge CLOCK_50) begin
        if (reset || !enable) begin
            lockout_q <= '0;
        end else if (fire) begin
            lockout_q <= LOCK_W'(LOCKOUT_CYCLES);
        end else if (lockout_busy) begin
            lockout_q <= lockout_q - 1'b1;
        end
    end
`else
    assign lockout_busy = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= WAIT;
            left_q        <= '0;
            right_q       <= '0;
            mag_q         <= '0;
            win_peak_q    <= '0;
            count_q       <= '0;
            loud_cnt_q    <= '0;
            peak_level_q  <= '0;
            level_valid_q <= 1'b0;
            loud_q        <= 1'b0;
            sound_q       <= 1'b0;
        end else begin
            level_valid_q <= 1'b0;
            sound_q       <= fire;
            if (!enable) begin
                state_q    <= WAIT;
                count_q    <= '0;
                win_peak_q <= '0;
                loud_cnt_q <= '0;
            end else begin
                case (state_q)
                    WAIT: begin
                        if (read_d) begin
                            left_q  <= left_channel_audio_in;
                            right_q <= right_channel_audio_in;
                            state_q <= MAG;
                        end
                    end
                    MAG: begin
                        mag_q   <= mag_d;
                        state_q <= UPDATE;
                    end
                    UPDATE: begin
                        state_q <= WAIT;
                        if (window_end) begin
                            peak_level_q  <= peak_d;
                            level_valid_q <= 1'b1;
                            loud_q        <= window_loud;
                            win_peak_q    <= '0;
                            count_q       <= '0;
                            if (lockout_busy || !window_loud) begin
                                loud_cnt_q <= '0;
                            end else if (loud_cnt_q < HOLD_V) begin
                                loud_cnt_q <= loud_cnt_q + 4'd1;
                            end
                        end else begin
                            win_peak_q <= peak_d;
                            count_q    <= count_q + 1'b1;
                        end
                    end
                    default: state_q <= WAIT;
                endcase
            end
        end
    end

    assign read_audio_in  = read_d;
    assign peak_level     = peak_level_q;
    assign level_valid    = level_valid_q;
    assign loud           = loud_q;
    assign sound_detected = sound_q;

endmodule

// File: tb/tb_audio_level_detector.sv
// Directed bench for audio_level_detector: a window model pushes expected results at pop time.
`timescale 1ns/1ps
module tb_audio_level_detector;

    localparam int     W    = 32;
    localparam longint THR  = 5000000;
    localparam int     HOLD = 2;
    localparam int     WIN  = 1024;

    typedef struct {
        longint peak;
        logic   loud;
        logic   snd;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         avail;
    logic [W-1:0] left_s;
    logic [W-1:0] right_s;
    logic         rd;
    logic [W-2:0] peak;
    logic         lv;
    logic         loud;
    logic         snd;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint peak_m = 0;
    int     count_m = 0;
    int     lc_m = 0;
    longint last_peak_m = 0;
    logic   last_loud_m = 1'b0;
    int     cyc_n = 0;
    int     last_rd = -10;
    int     popped = 0;
    bit     gap3 = 1'b0;

    always #5 clk = ~clk;

    audio_level_detector dut (
        .CLOCK_50              (clk),
        .reset                 (reset),
        .enable                (enable),
        .audio_in_available    (avail),
        .left_channel_audio_in (left_s),
        .right_channel_audio_in(right_s),
        .read_audio_in         (rd),
        .peak_level            (peak),
        .level_valid           (lv),
        .loud                  (loud),
        .sound_detected        (snd)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint absm(input logic [W-1:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v;
    endfunction

    task automatic model_pop(input logic [W-1:0] l, input logic [W-1:0] r);
        exp_t   e;
        longint m;
        logic   lw;
        m = (absm(l) > absm(r)) ? absm(l) : absm(r);
        if (m > peak_m) peak_m = m;
        count_m++;
        if (count_m == WIN) begin
            lw     = (peak_m > THR);
            e.peak = peak_m;
            e.loud = lw;
            e.snd  = 1'b0;
            if (lw) begin
                if (lc_m < HOLD) begin
                    lc_m++;
                    e.snd = (lc_m == HOLD);
                end
            end else begin
                lc_m = 0;
            end
            sb.push_back(e);
            last_peak_m = peak_m;
            last_loud_m = lw;
            peak_m  = 0;
            count_m = 0;
        end
    endtask

    task automatic set_data(input int mode, input int k);
        case (mode)
            1:       begin left_s = 32'd6000000;                    right_s = -32'sd100;      end
            2:       begin left_s = (k == 7) ? 32'h8000_0000 : '0;  right_s = '0;             end
            3:       begin left_s = 32'(k * 3);                     right_s = -32'(k);        end
            4:       begin left_s = $urandom;                       right_s = $urandom;       end
            5:       begin left_s = 32'd5000000;                    right_s = -32'sd5000000;  end
            6:       begin left_s = '0;                             right_s = -32'sd5000001;  end
            default: begin left_s = '0;                             right_s = '0;             end
        endcase
    endtask

    // One clock: check outputs at the falling edge, model any pop the DUT is making.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        if (lv) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_level_valid: got level_valid=1 expected no window end");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("peak_level", longint'(peak), e.peak);
                check("loud", longint'(loud), longint'(e.loud));
                check("sound_detected", longint'(snd), longint'(e.snd));
            end
        end else begin
            check("sound_without_level_valid", longint'(snd), 0);
        end
        if (rd) begin
            if (last_rd >= 0) check("read_not_back_to_back", longint'(cyc_n - last_rd > 1), 1);
            if (gap3 && last_rd >= 0) check("pop_gap", longint'(cyc_n - last_rd), 3);
            last_rd = cyc_n;
            model_pop(left_s, right_s);
            popped++;
        end
    endtask

    task automatic feed(input int n, input int mode);
        int start;
        int guard;
        start = popped;
        guard = 0;
        @(posedge clk); #1;
        set_data(mode, 0);
        avail = 1'b1;
        while ((popped - start) < n && guard < 4 * n + 20) begin
            tick();
            guard++;
            if ((popped - start) < n) begin
                @(posedge clk); #1;
                set_data(mode, popped - start);
            end
        end
        check("feed_pops_within_budget", longint'(popped - start), longint'(n));
        @(posedge clk); #1;
        avail = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        avail   = 1'b1;
        left_s  = '0;
        right_s = '0;
        repeat (3) begin
            @(negedge clk);
            check("read_during_reset", longint'(rd), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        avail = 1'b0;
        @(negedge clk);
        check("rst_read_audio_in", longint'(rd), 0);
        check("rst_peak_level", longint'(peak), 0);
        check("rst_level_valid", longint'(lv), 0);
        check("rst_loud", longint'(loud), 0);
        check("rst_sound_detected", longint'(snd), 0);

        // Silent window with continuous availability: pops every 3 clocks.
        last_rd = -10;
        gap3 = 1'b1;
        feed(WIN, 0);
        gap3 = 1'b0;

        // Four loud windows: single pulse at the second, then saturation.
        repeat (4) feed(WIN, 1);

        // Quiet, most-negative single sample, quiet.
        feed(WIN, 0);
        feed(WIN, 2);
        feed(WIN, 0);

        // Loud, quiet, loud: quiet window breaks the run.
        feed(WIN, 1);
        feed(WIN, 3);
        feed(WIN, 1);

        // Threshold boundary: exactly THRESHOLD is quiet, one above is loud twice -> pulse.
        feed(WIN, 5);
        feed(WIN, 6);
        feed(WIN, 6);

        feed(WIN, 4);
        idle(8);
        check("scoreboard_drained_1", longint'(sb.size()), 0);

        // Disable mid-window: partial window discarded, outputs held.
        feed(500, 1);
        idle(6);
        enable  = 1'b0;
        count_m = 0;
        peak_m  = 0;
        lc_m    = 0;
        avail   = 1'b1;
        repeat (20) begin
            tick();
            check("read_while_disabled", longint'(rd), 0);
        end
        check("peak_held_while_disabled", longint'(peak), last_peak_m);
        check("loud_held_while_disabled", longint'(loud), longint'(last_loud_m));
        @(posedge clk); #1;
        set_data(0, 0);
        enable = 1'b1;
        tick();
        check("pop_on_enable_rise", longint'(rd), 1);
        feed(WIN - 1, 0);
        idle(8);
        check("scoreboard_drained_2", longint'(sb.size()), 0);

        // Reset in the middle of a window.
        feed(300, 1);
        idle(2);
        @(posedge clk); #1;
        reset       = 1'b1;
        count_m     = 0;
        peak_m      = 0;
        lc_m        = 0;
        last_peak_m = 0;
        last_loud_m = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_peak_level", longint'(peak), 0);
        check("midrst_loud", longint'(loud), 0);
        feed(WIN, 6);
        idle(8);
        check("scoreboard_drained_3", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
